// File: rtl/fft_power_averager.sv
// Per-bin |X|^2 averaged over 2^AVG_LOG2 FFT frames via a read-modify-write accumulator RAM.
// Optional PEAK_HOLD_EN adds peak_power/peak_index tracking of each output spectrum.
module fft_power_averager #(
  parameter int FFT_SIZE    = 4096,
  parameter int DATA_WIDTH  = 24,
  parameter int AVG_LOG2    = 4,
  parameter int POWER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  real_in,
  input  logic [DATA_WIDTH-1:0]  imag_in,
  input  logic                   fft_valid,
  input  logic [11:0]            fft_index,
  output logic [POWER_WIDTH-1:0] power_out,
  output logic                   power_valid,
  output logic [11:0]            power_index,
  output logic                   frame_done,
`ifdef PEAK_HOLD_EN
  output logic [POWER_WIDTH-1:0] peak_power,
  output logic [11:0]            peak_index,
`endif
  output logic                   sync_err
);
  localparam int STAGES = 4;
  localparam int PW2    = 2 * DATA_WIDTH;
  localparam int ACC_W  = PW2 + AVG_LOG2;
  localparam int ADDR_W = $clog2(FFT_SIZE);
  localparam int FCW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FCW-1:0] FC_LAST  = FCW'((1 << AVG_LOG2) - 1);
  localparam logic [11:0]    LAST_IDX = 12'(FFT_SIZE - 1);

  typedef enum logic {WAIT_SYNC, ACCUM} state_t;
  typedef struct packed {
    logic [11:0] idx;
    logic        first;
    logic        last;
  } tag_t;

  state_t         state, state_n;
  logic [11:0]    exp_idx, exp_n;
  logic [FCW-1:0] fc, fc_n, proc_fc;
  logic           accept, err, fresh;
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_SYNC;
      exp_idx <= '0;
      fc      <= '0;
    end else begin
      state   <= state_n;
      exp_idx <= exp_n;
      fc      <= fc_n;
    end
  end

  always_comb begin
    state_n = state;
    exp_n   = exp_idx;
    fc_n    = fc;
    if (fresh) begin
      state_n = ACCUM;
      exp_n   = 12'd1;
      fc_n    = '0;
    end else if (accept) begin
      if (exp_idx == LAST_IDX) begin
        exp_n = '0;
        fc_n  = (fc == FC_LAST) ? '0 : fc + FCW'(1);
      end else begin
        exp_n = exp_idx + 12'd1;
      end
    end else if (err) begin
      state_n = WAIT_SYNC;
      exp_n   = '0;
      fc_n    = '0;
    end
  end

  // A bad index is dropped, but an index-0 sample doubles as an immediate resync.
  always_comb begin
    accept = 1'b0;
    err    = 1'b0;
    fresh  = 1'b0;
    case (state)
      WAIT_SYNC: if (fft_valid && fft_index == 12'd0) begin
        accept = 1'b1;
        fresh  = 1'b1;
      end
      ACCUM: if (fft_valid) begin
        if (fft_index == exp_idx) begin
          accept = 1'b1;
        end else begin
          err = 1'b1;
          if (fft_index == 12'd0) begin
            accept = 1'b1;
            fresh  = 1'b1;
          end
        end
      end
      default: ;
    endcase
    proc_fc = fresh ? '0 : fc;
  end

  logic signed [DATA_WIDTH-1:0] s1_re, s1_im;
  tag_t                         s1_tag, s2_tag, s3_tag;
  logic [PW2-1:0]               s2_sq_re, s2_sq_im, s3_p;
  logic [ACC_W-1:0]             s3_rd, acc;
  logic [POWER_WIDTH-1:0]       s4_out;
  logic [11:0]                  s4_idx;
  logic                         s4_last;
  logic [ACC_W-1:0]             mem [FFT_SIZE];

  assign acc = s3_tag.first ? ACC_W'(s3_p) : s3_rd + ACC_W'(s3_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      sync_err    <= 1'b0;
      s1_re       <= '0;
      s1_im       <= '0;
      s1_tag      <= '0;
      s2_sq_re    <= '0;
      s2_sq_im    <= '0;
      s2_tag      <= '0;
      s3_p        <= '0;
      s3_tag      <= '0;
      s4_out      <= '0;
      s4_idx      <= '0;
      s4_last     <= 1'b0;
      power_out   <= '0;
      power_valid <= 1'b0;
      power_index <= '0;
      frame_done  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      sync_err <= err;
      s1_re    <= $signed(real_in);
      s1_im    <= $signed(imag_in);
      s1_tag   <= '{idx: fft_index, first: (proc_fc == '0), last: (proc_fc == FC_LAST)};
      s2_sq_re <= PW2'(s1_re * s1_re);
      s2_sq_im <= PW2'(s1_im * s1_im);
      s2_tag   <= s1_tag;
      s3_p     <= s2_sq_re + s2_sq_im;
      s3_tag   <= s2_tag;
      // Average and narrow in one slice: drop AVG_LOG2 + (PW2-POWER_WIDTH) LSBs.
      s4_out   <= acc[ACC_W-1 -: POWER_WIDTH];
      s4_idx   <= s3_tag.idx;
      s4_last  <= s3_tag.last;
      power_valid <= vld_pipe[4] & s4_last;
      frame_done  <= vld_pipe[4] & s4_last & (s4_idx == LAST_IDX);
      if (vld_pipe[4] && s4_last) begin
        power_out   <= s4_out;
        power_index <= s4_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_pipe[3]) mem[s3_tag.idx[ADDR_W-1:0]] <= acc;
    s3_rd <= mem[s2_tag.idx[ADDR_W-1:0]];
  end

`ifdef PEAK_HOLD_EN
  logic [POWER_WIDTH-1:0] run_max, cand_max;
  logic [11:0]            run_idx, cand_idx;

  // Strict compare keeps the lowest index on ties; bin 0 restarts the search.
  always_comb begin
    cand_max = run_max;
    cand_idx = run_idx;
    if (power_index == 12'd0 || power_out > run_max) begin
      cand_max = power_out;
      cand_idx = power_index;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max    <= '0;
      run_idx    <= '0;
      peak_power <= '0;
      peak_index <= '0;
    end else if (power_valid) begin
      run_max <= cand_max;
      run_idx <= cand_idx;
      if (frame_done) begin
        peak_power <= cand_max;
        peak_index <= cand_idx;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fft_power_averager.sv
// Directed bench for fft_power_averager: FFT_SIZE=16, AVG_LOG2=2, output shift 16.
module tb_fft_power_averager;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] real_in = '0, imag_in = '0;
  logic        fft_valid = 1'b0;
  logic [11:0] fft_index = '0;
  logic [31:0] power_out;
  logic        power_valid;
  logic [11:0] power_index;
  logic        frame_done, sync_err;
`ifdef PEAK_HOLD_EN
  logic [31:0] peak_power;
  logic [11:0] peak_index;
`endif

  fft_power_averager #(.FFT_SIZE(N), .DATA_WIDTH(24), .AVG_LOG2(2), .POWER_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .real_in(real_in), .imag_in(imag_in),
    .fft_valid(fft_valid), .fft_index(fft_index), .power_out(power_out),
    .power_valid(power_valid), .power_index(power_index), .frame_done(frame_done),
`ifdef PEAK_HOLD_EN
    .peak_power(peak_power), .peak_index(peak_index),
`endif
    .sync_err(sync_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, bin0_cyc = 0, n_sync = 0, n_orphan = 0;
  logic [31:0] pw_q[$];
  logic [11:0] ix_q[$];
  logic        fd_q[$];
  int          sc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (power_valid) begin
      pw_q.push_back(power_out);
      ix_q.push_back(power_index);
      fd_q.push_back(frame_done);
      sc_q.push_back(cyc);
    end
    if (frame_done && !power_valid) n_orphan++;
    if (sync_err) n_sync++;
  end

`ifdef PEAK_HOLD_EN
  logic        fd_d = 1'b0;
  logic [31:0] pk_pw = '0;
  logic [11:0] pk_ix = '0;
  always @(negedge clk) begin
    if (fd_d) begin
      pk_pw = peak_power;
      pk_ix = peak_index;
    end
    fd_d = frame_done;
  end
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bin(input int re, input int im, input int idx);
    real_in   = re[23:0];
    imag_in   = im[23:0];
    fft_index = idx[11:0];
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    if (idx == 0) bin0_cyc = cyc;
  endtask

  task automatic idle(input int n);
    fft_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int re, input int im, input bit gaps, input bit hot);
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
      if (hot && (i == 5 || i == 11)) send_bin(8192, 0, i);
      else send_bin(re, im, i);
    end
  endtask

  task automatic clear();
    pw_q.delete();
    ix_q.delete();
    fd_q.delete();
    sc_q.delete();
    n_sync   = 0;
    n_orphan = 0;
  endtask

  task automatic check_spec(input string tag, input logic [31:0] exp_pw, input int exp_sync);
    idle(10);
    chk({tag, " strobes"}, pw_q.size(), N);
    chk({tag, " sync_err"}, n_sync, exp_sync);
    chk({tag, " stray frame_done"}, n_orphan, 0);
    for (int i = 0; i < N && i < pw_q.size(); i++) begin
      chk($sformatf("%s pw[%0d]", tag, i), pw_q[i], exp_pw);
      chk($sformatf("%s idx[%0d]", tag, i), ix_q[i], i);
      chk($sformatf("%s fd[%0d]", tag, i), fd_q[i], (i == N - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst power_out", power_out, 0);
    chk("rst power_valid", power_valid, 0);
    chk("rst power_index", power_index, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst sync_err", sync_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Constant 2^24 power, plus latency from bin-0 acceptance of the last frame.
    clear();
    for (int f = 0; f < 4; f++) send_frame(4096, 0, 0, 0);
    chk("lat first strobe", (sc_q.size() > 0) ? sc_q[0] - bin0_cyc : -1, 4);
    check_spec("const", 32'd256, 0);

    clear();
    for (int f = 0; f < 4; f++) send_frame(-4096, 4096, 0, 0);
    check_spec("cplx", 32'd512, 0);

    clear();
    for (int f = 0; f < 4; f++) send_frame(-8388608, -8388608, 0, 0);
    check_spec("fullscale", 32'h8000_0000, 0);

    clear();
    for (int f = 0; f < 4; f++) send_frame((f % 2 == 0) ? 4096 : 0, 0, 0, 0);
    check_spec("alt", 32'd128, 0);

    clear();
    for (int f = 0; f < 4; f++) send_frame(4096, 0, 1, 0);
    check_spec("gaps", 32'd256, 0);

    // Jump 5 -> 9 drops to WAIT_SYNC; 10..15 are ignored without further errors.
    clear();
    send_frame(4096, 0, 0, 0);
    for (int i = 0; i < 6; i++) send_bin(8192, 0, i);
    send_bin(8192, 0, 9);
    for (int i = 10; i < N; i++) send_bin(8192, 0, i);
    for (int f = 0; f < 4; f++) send_frame(-4096, 4096, 0, 0);
    check_spec("jump", 32'd512, 1);

    // Unexpected index 0 mid-frame restarts immediately as a fresh bin 0.
    clear();
    for (int i = 0; i < 3; i++) send_bin(8192, 0, i);
    for (int f = 0; f < 4; f++) send_frame(4096, 0, 0, 0);
    check_spec("restart0", 32'd256, 1);

    // Reset during frame 3 with distinct data left behind in the RAM.
    send_frame(4096, 0, 0, 0);
    send_frame(4096, 0, 0, 0);
    for (int i = 0; i < 8; i++) send_bin(8192, 0, i);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst power_out", power_out, 0);
    chk("midrst power_valid", power_valid, 0);
    chk("midrst power_index", power_index, 0);
    chk("midrst frame_done", frame_done, 0);
    chk("midrst sync_err", sync_err, 0);
    idle(3);
    rst_n = 1'b1;
    clear();
    idle(2);
    for (int f = 0; f < 4; f++) send_frame(4096, 0, 0, 0);
    check_spec("postrst", 32'd256, 0);

`ifdef PEAK_HOLD_EN
    clear();
    for (int f = 0; f < 4; f++) send_frame(4096, 0, 0, 1);
    idle(10);
    chk("peak strobes", pw_q.size(), N);
    chk("peak power", pk_pw, 1024);
    chk("peak index", pk_ix, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fft_power_averager.md
# fft_power_averager

Downstream consumer of the FFT processor. Takes the bin stream (real/imag, valid, bin index), forms per-bin power |X|², and averages it over 2^AVG_LOG2 consecutive FFT frames in an on-chip accumulator RAM. Emits one averaged spectrum (FFT_SIZE bins, in index order) per averaging period. It feeds the spectrum readout/host interface.

## Interface
- FFT_SIZE, 4096: bins per frame; power of two, 8..4096.
- DATA_WIDTH, 24: signed two's-complement width of real/imag input.
- AVG_LOG2, 4: log2 of frames averaged per output; 0..8.
- POWER_WIDTH, 32: output power width; must be ≤ 2*DATA_WIDTH.

- clk  in  1  processing clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- real_in  in  DATA_WIDTH  signed bin real part.
- imag_in  in  DATA_WIDTH  signed bin imaginary part.
- fft_valid  in  1  input bin valid.
- fft_index  in  12  input bin index, 0..FFT_SIZE-1.
- power_out  out  POWER_WIDTH  averaged power, unsigned.
- power_valid  out  1  power_out/power_index valid, one-cycle-per-bin strobe.
- power_index  out  12  bin index of power_out.
- frame_done  out  1  one-cycle pulse coincident with the output of bin FFT_SIZE-1.
- sync_err  out  1  one-cycle pulse on an index discontinuity.

## Operation
- Power: p = re² + im², both signed; the result is 2*DATA_WIDTH bits unsigned, with max value 2^(2*DATA_WIDTH-1). There is no overflow.
- Accumulator RAM: FFT_SIZE words × (2*DATA_WIDTH+AVG_LOG2) bits, addressed by bin index, read-modify-write.
- Frame counter fc runs 0..2^AVG_LOG2-1.
  - fc==0: write acc = p. This overwrites, so the RAM needs no clearing.
  - Otherwise: write acc = acc + p.
  - fc==last: output acc+p. The RAM write is don't-care.
- Output scaling: power_out = (sum >> AVG_LOG2) >> (2*DATA_WIDTH-POWER_WIDTH). The truncating shift is exact and needs no saturation.
- AVG_LOG2=0: every frame is output directly.
- State machine:
  - WAIT_SYNC (reset state): ignore samples until fft_valid with fft_index==0. That sample is processed as bin 0 with fc=0, and the state moves to ACCUM with expected index 1.
  - ACCUM: each fft_valid sample must carry fft_index == expected.
    - On a match, process the sample and increment expected.
    - After FFT_SIZE-1, expected wraps to 0 and fc increments, wrapping to 0 after last.
    - On a mismatch: drop the sample, pulse sync_err, set fc=0. If that sample's index is 0, process it as a fresh bin 0 and stay in ACCUM; otherwise go to WAIT_SYNC.
- Gaps in fft_valid are allowed anywhere; expected holds during gaps.
- Samples already in the pipeline always complete; sync_err affects subsequent samples only. A partially accumulated period is discarded and never output.
- RAM hazard: the same address recurs only after ≥FFT_SIZE≥8 accepted samples, so no forwarding is required.

## Timing
- Pipeline has 4 stages:
  - S1: input register.
  - S2: squares.
  - S3: sum + RAM read.
  - S4: accumulate / write / output register.
- Latency: a last-frame sample accepted at edge N gives power_valid high after edge N+4.
- Throughput: one bin per clock, sustained.
- Reset values: power_out=0, power_valid=0, power_index=0, frame_done=0, sync_err=0, fc=0, state=WAIT_SYNC. All pipeline valids are cleared; RAM contents are not.
- Reset mid-frame aborts everything in flight. No output appears until a full period completes after a new bin-0 sync.
- sync_err asserts 1 cycle after the offending sample is accepted.
- frame_done and power_valid assert in the same cycle for bin FFT_SIZE-1.

## Configuration
- PEAK_HOLD_EN defined:
  - Adds outputs peak_power [POWER_WIDTH] and peak_index [12].
  - Both update in the frame_done cycle +1 to the maximum power_out of that output spectrum and its bin.
  - Ties resolve to the lowest index.
  - Reset value of both is 0; they hold between updates.
- PEAK_HOLD_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
Bench parameters: FFT_SIZE=16, DATA_WIDTH=24, AVG_LOG2=2, POWER_WIDTH=32 (shift 16).
- Constant re=4096, im=0 on all bins, 4 frames back-to-back -> after frame 4, 16 strobes with power_out=256 and power_index 0..15. frame_done is high with index 15. Latency is 4 cycles.
- re=-4096, im=4096 -> 512. Full-scale re=im=-2^23 -> 2^31 (0x80000000). The frame alternates 2^24 power, 0, 2^24, 0 per frame -> 128.
- Random fft_valid gaps (50% duty) with the same data as case 1 -> identical output values and indices; no sync_err.
- Index jump 0..5 then 9 in frame 2 -> sync_err pulse, no output. Resync at the next index 0; output appears only after 4 further complete frames, and the values contain no stale contribution.
- Assert rst_n low mid-frame 3, release, then feed 4 frames of 2^24 power -> all outputs 0 during reset. The first spectrum equals 256 on all bins, with no influence from the pre-reset RAM.
- With PEAK_HOLD_EN: bins 5 and 11 at re=8192 (power 1024 out), others 4096 -> peak_power=1024, peak_index=5 one cycle after frame_done.
